// File: rtl/reset_seq_pkg.sv
// Shared state encoding and default timing constants for the staged reset sequencer.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'd0,
      ST_HOLD    = 2'd1,
      ST_RELEASE = 2'd2,
      ST_RUN     = 2'd3
   } seq_state_t;

   localparam int DEFAULT_NUM_STAGES  = 3;
   localparam int DEFAULT_HOLD_CYCLES = 16;
   localparam int DEFAULT_GAP_CYCLES  = 8;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/reset_sequencer.sv
// Staged reset release: holds all resets after a request clears, then releases
// the stages one by one, lowest bit first, with a fixed gap between stages.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_STAGES  = DEFAULT_NUM_STAGES,
   parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
   parameter int GAP_CYCLES  = DEFAULT_GAP_CYCLES
) (
   input  logic                  iclk,
   input  logic                  irst,
   input  logic                  ireq_n,
   input  logic                  isw_req,
   output logic [NUM_STAGES-1:0] orst_n,
   output logic                  odone,
   output logic [1:0]            ostate
);

   localparam int CNT_MAX = max_int(HOLD_CYCLES, GAP_CYCLES);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int STAGE_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(GAP_CYCLES);
   localparam logic [CNT_W-1:0]   CNT_TOP    = CNT_W'(CNT_MAX);
   localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

   generate
      if (NUM_STAGES < 1 || HOLD_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_params
         $error("reset_sequencer: NUM_STAGES, HOLD_CYCLES and GAP_CYCLES must all be at least 1");
      end
   endgenerate

   seq_state_t             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
   logic [STAGE_W-1:0]     stage_q, stage_d, stage_nxt;
   logic [NUM_STAGES-1:0]  rst_n_d;
   logic                   done_d;
   logic                   req_active;

   assign req_active = ~ireq_n | isw_req;
   assign cnt_inc    = (cnt_q < CNT_TOP) ? cnt_q + 1'b1 : cnt_q;
   assign stage_nxt  = stage_q + 1'b1;

   // State, counter and the registered outputs all update together so the
   // outputs never depend combinationally on the request inputs.
   always_ff @(posedge iclk) begin
      if (irst) begin
         state_q <= ST_ASSERT;
         cnt_q   <= '0;
         stage_q <= '0;
         orst_n  <= '0;
         odone   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stage_q <= stage_d;
         orst_n  <= rst_n_d;
         odone   <= done_d;
      end
   end

   // The counter restarts at 1 on every phase change, so a phase ends when
   // the counter reaches its length; it saturates instead of wrapping.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stage_d = stage_q;
      if (req_active) begin
         state_d = ST_ASSERT;
         cnt_d   = '0;
         stage_d = '0;
      end else begin
         case (state_q)
            ST_ASSERT: begin
               state_d = ST_HOLD;
               cnt_d   = CNT_W'(1);
            end
            ST_HOLD: begin
               if (cnt_q >= HOLD_LAST) begin
                  state_d = (NUM_STAGES == 1) ? ST_RUN : ST_RELEASE;
                  cnt_d   = CNT_W'(1);
                  stage_d = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            ST_RELEASE: begin
               if (cnt_q >= GAP_LAST) begin
                  stage_d = stage_nxt;
                  cnt_d   = CNT_W'(1);
                  if (stage_nxt == LAST_STAGE) begin
                     state_d = ST_RUN;
                  end
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            ST_RUN: begin
               cnt_d = cnt_q;
            end
            default: begin
               state_d = ST_ASSERT;
               cnt_d   = '0;
               stage_d = '0;
            end
         endcase
      end
   end

   // Output values are derived from the upcoming state and stage index, then registered.
   always_comb begin
      rst_n_d = '0;
      done_d  = 1'b0;
      case (state_d)
         ST_RELEASE: begin
            for (int k = 0; k < NUM_STAGES; k++) begin
               rst_n_d[k] = (k <= int'(stage_d));
            end
         end
         ST_RUN: begin
            rst_n_d = '1;
            done_d  = 1'b1;
         end
         default: begin
            rst_n_d = '0;
         end
      endcase
   end

   assign ostate = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench: a default-parameter sequencer and a minimal 1/1/1 one
// share stimulus and are compared each cycle against elapsed-time arithmetic.
module tb_reset_sequencer;

   localparam int S0 = 3, H0 = 16, G0 = 8;
   localparam int S1 = 1, H1 = 1,  G1 = 1;

   logic          iclk = 1'b0;
   logic          irst = 1'b1;
   logic          ireq_n = 1'b1;
   logic          isw_req = 1'b0;
   logic [S0-1:0] orst_n_a;
   logic          odone_a;
   logic [1:0]    ostate_a;
   logic [S1-1:0] orst_n_b;
   logic          odone_b;
   logic [1:0]    ostate_b;

   int checks = 0;
   int errors = 0;
   int el_a = -1;
   int el_b = -1;

   always #5 iclk = ~iclk;

   reset_sequencer #(.NUM_STAGES(S0), .HOLD_CYCLES(H0), .GAP_CYCLES(G0)) dut_a (
      .iclk(iclk), .irst(irst), .ireq_n(ireq_n), .isw_req(isw_req),
      .orst_n(orst_n_a), .odone(odone_a), .ostate(ostate_a)
   );

   reset_sequencer #(.NUM_STAGES(S1), .HOLD_CYCLES(H1), .GAP_CYCLES(G1)) dut_b (
      .iclk(iclk), .irst(irst), .ireq_n(ireq_n), .isw_req(isw_req),
      .orst_n(orst_n_b), .odone(odone_b), .ostate(ostate_b)
   );

   // el is the number of edges since the request first went inactive; -1 while asserted.
   function automatic logic [7:0] exp_rst(input int el, input int s, input int h, input int g);
      logic [7:0] v = '0;
      for (int k = 0; k < s; k++) v[k] = (el >= 0) && (el >= h + k * g);
      return v;
   endfunction

   function automatic logic exp_done(input int el, input int s, input int h, input int g);
      return (el >= 0) && (el >= h + (s - 1) * g);
   endfunction

   function automatic logic [1:0] exp_state(input int el, input int s, input int h, input int g);
      if (el < 0) return 2'd0;
      if (el < h) return 2'd1;
      if (el < h + (s - 1) * g) return 2'd2;
      return 2'd3;
   endfunction

   task automatic check_output();
      logic [7:0] ea = exp_rst(el_a, S0, H0, G0);
      logic [7:0] eb = exp_rst(el_b, S1, H1, G1);
      checks++;
      assert (orst_n_a === ea[S0-1:0]) else begin
         errors++; $error("[TB] FAIL orst_n_a el=%0d observed=%b expected=%b", el_a, orst_n_a, ea[S0-1:0]);
      end
      checks++;
      assert (odone_a === exp_done(el_a, S0, H0, G0)) else begin
         errors++; $error("[TB] FAIL odone_a el=%0d observed=%b expected=%b", el_a, odone_a, exp_done(el_a, S0, H0, G0));
      end
      checks++;
      assert (ostate_a === exp_state(el_a, S0, H0, G0)) else begin
         errors++; $error("[TB] FAIL ostate_a el=%0d observed=%0d expected=%0d", el_a, ostate_a, exp_state(el_a, S0, H0, G0));
      end
      checks++;
      assert (orst_n_b === eb[S1-1:0]) else begin
         errors++; $error("[TB] FAIL orst_n_b el=%0d observed=%b expected=%b", el_b, orst_n_b, eb[S1-1:0]);
      end
      checks++;
      assert (odone_b === exp_done(el_b, S1, H1, G1)) else begin
         errors++; $error("[TB] FAIL odone_b el=%0d observed=%b expected=%b", el_b, odone_b, exp_done(el_b, S1, H1, G1));
      end
      checks++;
      assert (ostate_b === exp_state(el_b, S1, H1, G1)) else begin
         errors++; $error("[TB] FAIL ostate_b el=%0d observed=%0d expected=%0d", el_b, ostate_b, exp_state(el_b, S1, H1, G1));
      end
   endtask

   // Drive one cycle of inputs away from the edge, advance the model at the edge, check after it.
   task automatic apply_stimulus(input logic rst, input logic req_n, input logic sw);
      @(negedge iclk);
      irst    = rst;
      ireq_n  = req_n;
      isw_req = sw;
      @(posedge iclk);
      if (rst || !req_n || sw) begin
         el_a = -1;
         el_b = -1;
      end else begin
         el_a = (el_a < 0) ? 0 : ((el_a < 100000) ? el_a + 1 : el_a);
         el_b = (el_b < 0) ? 0 : ((el_b < 100000) ? el_b + 1 : el_b);
      end
      #1;
      check_output();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      int burst;
      logic burst_sw;
      $display("[TB] power-up reset");
      for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b1, 1'b0);
      idle(40);

      $display("[TB] hardware request in RUN");
      for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0, 1'b0);
      idle(40);

      $display("[TB] abort mid-HOLD");
      for (int i = 0; i < 2; i++) apply_stimulus(1'b0, 1'b0, 1'b0);
      idle(10);
      apply_stimulus(1'b0, 1'b0, 1'b0);
      idle(40);

      $display("[TB] abort mid-RELEASE");
      apply_stimulus(1'b0, 1'b1, 1'b1);
      idle(18);
      apply_stimulus(1'b0, 1'b1, 1'b1);
      idle(40);

      $display("[TB] reset and software request together");
      apply_stimulus(1'b1, 1'b1, 1'b1);
      apply_stimulus(1'b1, 1'b0, 1'b1);
      idle(40);

      $display("[TB] randomized requests");
      burst = 0;
      burst_sw = 1'b0;
      for (int i = 0; i < 700; i++) begin
         if (burst == 0 && $urandom_range(0, 29) == 0) begin
            burst = int'($urandom_range(1, 4));
            burst_sw = 1'($urandom_range(0, 1));
         end
         if (burst > 0) begin
            burst--;
            apply_stimulus(1'($urandom_range(0, 7) == 0), burst_sw, burst_sw);
         end else begin
            apply_stimulus(1'b0, 1'b1, 1'b0);
         end
      end

      $display("[TB] long RUN without counter wrap");
      apply_stimulus(1'b0, 1'b0, 1'b0);
      idle(1040);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 3: number of staged reset outputs.
REQ-002 Parameter HOLD_CYCLES, default 16: cycles all outputs stay asserted after the request clears.
REQ-003 Parameter GAP_CYCLES, default 8: cycles between successive stage releases.
REQ-004 Port iclk  input  1  sole clock; all logic on its rising edge.
REQ-005 Port irst  input  1  reset, synchronous, active-high.
REQ-006 Port ireq_n  input  1  debounced reset request, active-low, already in the iclk domain (driven by debouncer orst_n).
REQ-007 Port isw_req  input  1  software reset request, active-high, single- or multi-cycle.
REQ-008 Port orst_n  output  NUM_STAGES  staged resets, active-low, bit 0 released first.
REQ-009 Port odone  output  1  high when all stages are released.
REQ-010 Port ostate  output  2  current FSM state encoding, for debug.

Function
REQ-011 The FSM SHALL have states ASSERT=0, HOLD=1, RELEASE=2, RUN=3.
REQ-012 Request active = (ireq_n==0) OR (isw_req==1), sampled each rising edge.
REQ-013 In any state, a sampled active request SHALL move the FSM to ASSERT and clear the counter and stage index at that edge.
REQ-014 In ASSERT with no active request, the FSM SHALL move to HOLD and load the counter with 1.
REQ-015 HOLD SHALL last exactly HOLD_CYCLES cycles, then move to RELEASE and drive orst_n[0]=1 at the same edge.
REQ-016 In RELEASE, orst_n[k] SHALL go high exactly GAP_CYCLES cycles after orst_n[k-1], for k = 1..NUM_STAGES-1.
REQ-017 With request first inactive at edge E0, orst_n[k] SHALL rise at edge E0+HOLD_CYCLES+k*GAP_CYCLES.
REQ-018 On releasing stage NUM_STAGES-1, the FSM SHALL enter RUN, with odone=1 at that same edge.
REQ-019 Released stages SHALL stay high until a new active request. Outputs SHALL never be released out of order.
REQ-020 On an active request, all orst_n bits SHALL be 0 and odone=0 after the sampling edge, with one-cycle latency.
REQ-021 A request during HOLD or RELEASE SHALL abort the sequence; a restart SHALL begin again from REQ-014 timing.
REQ-022 A one-cycle isw_req pulse in RUN SHALL produce a full sequence: 1 cycle in ASSERT, then HOLD, then RELEASE.
REQ-023 The counter SHALL be sized to max(HOLD_CYCLES, GAP_CYCLES) without wrap. It SHALL saturate and never wrap in any state.
REQ-024 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-025 HOLD_CYCLES<1, GAP_CYCLES<1 or NUM_STAGES<1 SHALL fail elaboration.

Reset
REQ-026 irst=1 at an edge SHALL force state ASSERT, orst_n all 0, odone=0, and counter and stage index 0.
REQ-027 irst SHALL take priority over ireq_n and isw_req.
REQ-028 After irst falls, sequencing SHALL start per REQ-014 if no request is active.

Structure
REQ-029 Package reset_seq_pkg SHALL hold the state typedef/encodings and the default HOLD_CYCLES, GAP_CYCLES and NUM_STAGES constants.
REQ-030 The block SHALL be a single module with the counter inline. No sub-module is required, because the input is already synchronized and debounced upstream.

Verification
REQ-031 Power-up: irst high 3 cycles, ireq_n=1 -> orst_n=000 during reset; bits 0,1,2 rise at edges E0+16, +24, +32; odone rises at +32.
REQ-032 Request in RUN: ireq_n low 5 cycles -> orst_n=000 and odone=0 one edge later; full 16/8/8 sequence after ireq_n returns high.
REQ-033 Abort mid-HOLD: ireq_n low 1 cycle at HOLD count 10 -> no release at original E0+16; release at new E0'+16.
REQ-034 Abort mid-RELEASE: isw_req pulse after orst_n=001 -> orst_n=000 next edge; restart sequence intact.
REQ-035 Simultaneous irst=1 and isw_req=1 -> reset behaviour only; state ASSERT, outputs 0.
REQ-036 Parameter sweep NUM_STAGES=1, HOLD_CYCLES=1, GAP_CYCLES=1 -> orst_n[0] and odone rise 1 edge after E0; no counter wrap in a 1000-cycle RUN.
